// File: rtl/dram_pattern_tester_if.sv
// DRAM wrapper user port: requests and write data from the tester, read data back from the wrapper.
interface dram_pattern_tester_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_wen;
  logic                  o_ren;
  logic [DATA_WIDTH-1:0] o_data;
  logic [MASK_WIDTH-1:0] o_mask;
  logic                  o_rd_busy;
  logic                  i_busy;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_data_valid;

  modport master (
    output o_addr, o_wen, o_ren, o_data, o_mask, o_rd_busy,
    input  i_busy, i_data, i_data_valid
  );

  modport slave (
    input  o_addr, o_wen, o_ren, o_data, o_mask, o_rd_busy,
    output i_busy, i_data, i_data_valid
  );
endinterface

// File: rtl/dram_pattern_tester.sv
// Writes an incrementing pattern to DRAM, reads it back and compares; requests are gated by i_busy,
// read issue is capped at MAX_OUTSTANDING in flight and a watchdog aborts on missing read data.
module dram_pattern_tester #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 128,
  parameter int MASK_WIDTH      = 16,
  parameter int LEN_WIDTH       = 16,
  parameter int ADDR_STEP       = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [31:0]           i_seed,
  dram_pattern_tester_if.master dram,
  output logic                  o_idle,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [15:0]           o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr
);
  localparam int NCOPY = DATA_WIDTH / 32;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [OW-1:0]         MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [WW-1:0]         WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [31:0]           seed_q, seed_d;
  logic [LEN_WIDTH-1:0]  iss_q, iss_d;
  logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
  logic [LEN_WIDTH-1:0]  rcv_q, rcv_d;
  logic [ADDR_WIDTH-1:0] rcv_addr_q, rcv_addr_d;
  logic [OW-1:0]         out_q, out_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
  logic                  pass_q, pass_d;
  logic                  tmo_q, tmo_d;

  logic        wen, ren, rd_phase, rd_vld, wd_expire;
  logic [31:0] wr_word, exp_word;

  assign rd_phase  = (state_q == S_READ) || (state_q == S_DRAIN);
  assign wen       = (state_q == S_WRITE) && !dram.i_busy;
  assign ren       = (state_q == S_READ) && !dram.i_busy && (out_q < MAX_OUT) && (iss_q < len_q);
  assign rd_vld    = rd_phase && dram.i_data_valid && (rcv_q != len_q);
  assign wd_expire = rd_phase && (out_q != '0) && !dram.i_data_valid && (wd_q == WD_LAST);
  assign wr_word   = seed_q + 32'(iss_q);
  assign exp_word  = seed_q + 32'(rcv_q);

  assign dram.o_wen     = wen;
  assign dram.o_ren     = ren;
  assign dram.o_addr    = iss_addr_q;
  assign dram.o_data    = {NCOPY{wr_word}};
  assign dram.o_mask    = '0;
  assign dram.o_rd_busy = 1'b0;

  assign o_idle           = (state_q == S_IDLE);
  assign o_done           = (state_q == S_DONE);
  assign o_pass           = pass_q;
  assign o_timeout        = tmo_q;
  assign o_err_count      = err_q;
  assign o_first_err_addr = ferr_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    seed_d     = seed_q;
    iss_d      = iss_q;
    iss_addr_d = iss_addr_q;
    rcv_d      = rcv_q;
    rcv_addr_d = rcv_addr_q;
    out_d      = out_q;
    wd_d       = '0;
    err_d      = err_q;
    ferr_d     = ferr_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;

    if (rd_vld) begin
      rcv_d      = rcv_q + 1'b1;
      rcv_addr_d = rcv_addr_q + STEP;
      if (dram.i_data != {NCOPY{exp_word}}) begin
        if (err_q == 16'h0000) ferr_d = rcv_addr_q;
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end
    end

    case ({ren, rd_vld && (out_q != '0)})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (rd_phase && (out_q != '0) && !dram.i_data_valid) wd_d = wd_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d     = i_base_addr;
          len_d      = i_len;
          seed_d     = i_seed;
          iss_d      = '0;
          iss_addr_d = i_base_addr;
          rcv_d      = '0;
          rcv_addr_d = i_base_addr;
          out_d      = '0;
          err_d      = '0;
          ferr_d     = '0;
          pass_d     = 1'b0;
          tmo_d      = 1'b0;
          state_d    = (i_len != '0) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        if (wen) begin
          iss_d      = iss_q + 1'b1;
          iss_addr_d = iss_addr_q + STEP;
          // Read phase restarts the issue counter and address from the base.
          if (iss_q == len_q - 1'b1) begin
            iss_d      = '0;
            iss_addr_d = base_q;
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        if (ren) begin
          iss_d      = iss_q + 1'b1;
          iss_addr_d = iss_addr_q + STEP;
          if (iss_q == len_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rcv_d == len_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wd_expire) begin
      tmo_d   = 1'b1;
      state_d = S_DONE;
    end

    // Verdict is formed on entry so it is valid together with the done pulse.
    if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = (err_d == 16'h0000) && !tmo_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      seed_q     <= '0;
      iss_q      <= '0;
      iss_addr_q <= '0;
      rcv_q      <= '0;
      rcv_addr_q <= '0;
      out_q      <= '0;
      wd_q       <= '0;
      err_q      <= '0;
      ferr_q     <= '0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      seed_q     <= seed_d;
      iss_q      <= iss_d;
      iss_addr_q <= iss_addr_d;
      rcv_q      <= rcv_d;
      rcv_addr_q <= rcv_addr_d;
      out_q      <= out_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
    end
  end
endmodule

// File: tb/tb_dram_pattern_tester.sv
// Bench for dram_pattern_tester: a DRAM wrapper model with memory, read latency, busy stalls and
// fault injection, and an expected-result model built from the pattern rules.
module tb_dram_pattern_tester;
  localparam int AW = 27;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic [31:0]   seed = '0;
  logic          idle, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  dram_pattern_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dif ();

  dram_pattern_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .LEN_WIDTH(LW),
    .ADDR_STEP(8), .MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_base_addr(base_addr), .i_len(len), .i_seed(seed),
    .dram(dif), .o_idle(idle), .o_done(done), .o_pass(pass), .o_timeout(timeout),
    .o_err_count(err_count), .o_first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [AW-1:0] addr; int idx; } rsp_t;

  int n_checks = 0;
  int n_errs = 0;
  int cyc = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  rsp_t rq[$];
  rsp_t head;

  logic [AW-1:0] r_base = '0;
  logic [31:0]   r_seed = '0;
  int r_len = 0;
  int wr_cnt = 0, rd_cnt = 0, busy_req = 0, out_cnt = 0, out_max = 0, last_vld_cyc = 0;
  int lat = 2, jit = 0, busy_pct = 0, corrupt_idx = -1, burst_left = 0;
  bit drop_last = 0, burst_mode = 0, burst_wr_done = 0, burst_rd_done = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] beat_addr(input int k);
    longint a;
    a = (longint'(r_base) + longint'(k) * 8) % (longint'(1) << AW);
    return a[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] beat_data(input int k);
    logic [31:0] w;
    w = r_seed + 32'(k);
    return {(DW/32){w}};
  endfunction

  // Observe requests between edges; each one seen here is accepted at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.i_busy && (dif.o_wen || dif.o_ren)) busy_req++;
      if (dif.o_wen && dif.o_ren) busy_req++;
      if (dif.o_wen) begin
        check("wr_addr", 128'(dif.o_addr), 128'(beat_addr(wr_cnt)));
        check("wr_data", dif.o_data, beat_data(wr_cnt));
        check("wr_mask", 128'(dif.o_mask), 128'(0));
        mem[dif.o_addr] = dif.o_data;
        wr_cnt++;
      end
      if (dif.o_ren) begin
        check("rd_addr", 128'(dif.o_addr), 128'(beat_addr(rd_cnt)));
        rq.push_back('{cyc + lat + int'($urandom_range(jit)), dif.o_addr, rd_cnt});
        rd_cnt++;
        out_cnt++;
      end
      if (dif.i_data_valid) out_cnt--;
      if (out_cnt > out_max) out_max = out_cnt;
    end
  end

  // Wrapper model: busy generation and in-order read returns.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (burst_left > 0) begin
      dif.i_busy = 1'b1;
      burst_left--;
    end else if (burst_mode && !burst_wr_done && wr_cnt == 6) begin
      dif.i_busy = 1'b1;
      burst_left = 4;
      burst_wr_done = 1'b1;
    end else if (burst_mode && !burst_rd_done && rd_cnt == 6) begin
      dif.i_busy = 1'b1;
      burst_left = 4;
      burst_rd_done = 1'b1;
    end else begin
      dif.i_busy = ($urandom_range(99) < busy_pct);
    end
    dif.i_data_valid = 1'b0;
    dif.i_data = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      head = rq.pop_front();
      if (!(drop_last && head.idx == r_len - 1)) begin
        dif.i_data_valid = 1'b1;
        dif.i_data = mem.exists(head.addr) ? mem[head.addr] : '0;
        if (head.idx == corrupt_idx) dif.i_data[5] = ~dif.i_data[5];
        last_vld_cyc = cyc;
      end
    end
  end

  task automatic launch(input logic [AW-1:0] b, input int n, input logic [31:0] s);
    @(posedge clk);
    #2;
    r_base = b; r_len = n; r_seed = s;
    wr_cnt = 0; rd_cnt = 0; busy_req = 0; out_cnt = 0; out_max = 0;
    rq.delete(); mem.delete();
    burst_left = 0; burst_wr_done = 0; burst_rd_done = 0;
    base_addr = b; len = LW'(n); seed = s; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    base_addr = ~b; len = 16'd3; seed = ~s;
  endtask

  task automatic run(input string tag, input logic [AW-1:0] b, input int n, input logic [31:0] s,
                     input bit poke);
    int exp_err;
    bit exp_tmo, exp_pass, got;
    logic [AW-1:0] exp_ferr;
    int done_cyc, d;
    launch(b, n, s);
    got = 0;
    done_cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        done_cyc = cyc;
        break;
      end
      start = poke && (i == 10) && !idle;
    end
    start = 1'b0;
    exp_err  = (corrupt_idx >= 0 && corrupt_idx < n) ? 1 : 0;
    exp_tmo  = drop_last && (n > 0);
    exp_ferr = (exp_err != 0) ? beat_addr(corrupt_idx) : '0;
    exp_pass = (exp_err == 0) && !exp_tmo;
    check({tag, ":done"}, 128'(got), 128'(1));
    check({tag, ":pass"}, 128'(pass), 128'(exp_pass));
    check({tag, ":err_count"}, 128'(err_count), 128'(exp_err));
    check({tag, ":first_err"}, 128'(first_err_addr), 128'(exp_ferr));
    check({tag, ":timeout"}, 128'(timeout), 128'(exp_tmo));
    check({tag, ":writes"}, 128'(wr_cnt), 128'(n));
    check({tag, ":reads"}, 128'(rd_cnt), 128'(n));
    check({tag, ":busy_req"}, 128'(busy_req), 128'(0));
    check({tag, ":out_le8"}, 128'(out_max <= 8), 128'(1));
    if (exp_tmo) begin
      d = done_cyc - last_vld_cyc;
      check({tag, ":tmo_delay"}, 128'(d >= 4096 && d <= 4098), 128'(1));
    end
    @(negedge clk);
    check({tag, ":idle_after"}, 128'(idle), 128'(1));
    check({tag, ":done_pulse"}, 128'(done), 128'(0));
    check({tag, ":hold_pass"}, 128'(pass), 128'(exp_pass));
  endtask

  initial begin
    int n, snap_wr, snap_rd;
    bit got;
    dif.i_busy = 1'b0;
    dif.i_data = '0;
    dif.i_data_valid = 1'b0;

    @(posedge clk);
    #1;
    check("rst:idle", 128'(idle), 128'(1));
    check("rst:wen", 128'(dif.o_wen), 128'(0));
    check("rst:ren", 128'(dif.o_ren), 128'(0));
    check("rst:pass", 128'(pass), 128'(0));
    check("rst:done", 128'(done), 128'(0));
    check("rst:rd_busy", 128'(dif.o_rd_busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    run("basic", 27'h100, 4, 32'hA5A5_0000, 1'b0);

    corrupt_idx = 0; lat = 20;
    launch(27'h4000, 16, 32'h1234_0000);
    got = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (err_count != 16'h0) begin
        got = 1;
        break;
      end
    end
    check("midrst:reached_read", 128'(got), 128'(1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst:idle", 128'(idle), 128'(1));
    check("midrst:ren", 128'(dif.o_ren), 128'(0));
    check("midrst:err", 128'(err_count), 128'(0));
    check("midrst:first_err", 128'(first_err_addr), 128'(0));
    check("midrst:addr", 128'(dif.o_addr), 128'(0));
    check("midrst:data", dif.o_data, 128'(0));
    snap_wr = wr_cnt;
    snap_rd = rd_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rq.delete();
    repeat (20) @(negedge clk);
    check("midrst:no_new_req", 128'(wr_cnt + rd_cnt), 128'(snap_wr + snap_rd));
    check("midrst:still_idle", 128'(idle), 128'(1));

    corrupt_idx = 2; lat = 3;
    run("corrupt", 27'h2000, 16, 32'hDEAD_0000, 1'b1);
    corrupt_idx = -1;

    burst_mode = 1; lat = 2;
    run("busy", 27'h3000, 16, 32'h0000_1000, 1'b0);
    check("busy:wr_burst", 128'(burst_wr_done), 128'(1));
    check("busy:rd_burst", 128'(burst_rd_done), 128'(1));
    burst_mode = 0;

    lat = 40;
    run("deep", 27'h5000, 20, 32'hFFFF_FFF8, 1'b0);
    check("deep:out_max", 128'(out_max), 128'(8));

    lat = 2; drop_last = 1;
    run("drop", 27'h6000, 4, 32'h0BAD_0000, 1'b0);
    drop_last = 0;

    run("len0", 27'h7000, 0, 32'h5555_5555, 1'b0);
    run("wrap", 27'h7FF_FFF0, 6, 32'h7FFF_FFFE, 1'b0);

    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(40, 1));
      lat = int'($urandom_range(12, 1));
      jit = int'($urandom_range(3));
      busy_pct = 30;
      corrupt_idx = ($urandom_range(1) == 1) ? int'($urandom_range(n - 1)) : -1;
      run($sformatf("rnd%0d", t), AW'($urandom), n, $urandom, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
